// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART tx arbiter and its round-robin picker:
// state encoding, the CR/LF byte values and the counter width.
package uart_arb_pkg;

    // Arbiter states; StCr is only reachable with TX_CRLF_EXPAND_EN defined.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StCr   = 2'd2
    } arb_state_e;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Burst and idle-timeout counters share one width.
    localparam int unsigned CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching upward from last+1, wrapping modulo N. Zero grant when idle.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic          found
);

    // Scan N positions starting just after the previous owner.
    always_comb begin
        int unsigned idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(last) + i) % N;
            if (!found && req[LW'(idx)]) begin
                gnt[LW'(idx)] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one UART tx write port among NUM_REQ FWFT byte sources.
// Grants are round-robin and held for a whole line: released on TERM_CHAR, after
// MAX_BURST bytes, or after IDLE_TO consecutive empty cycles of the owner.
// Optional build macro TX_CRLF_EXPAND_EN: an outgoing LF terminator is sent as
// CR followed by LF.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_BURST = 16,
    parameter logic [7:0]  TERM_CHAR = 8'h0A,
    parameter int unsigned IDLE_TO   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_empty,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_rd,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int unsigned LW         = $clog2(NUM_REQ);
    localparam cnt_t        BURST_LAST = cnt_t'(MAX_BURST - 1);
    localparam cnt_t        TO_LAST    = cnt_t'(IDLE_TO - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_chk
        $error("NUM_REQ must be in 2..8");
    end
    if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_burst_chk
        $error("MAX_BURST must be in 2..255");
    end
    if (IDLE_TO < 1 || IDLE_TO > 255) begin : g_to_chk
        $error("IDLE_TO must be in 1..255");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [LW-1:0]      last_q, last_d;
    cnt_t               burst_q, burst_d;
    cnt_t               to_q, to_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_found;
    logic [LW-1:0]      g_idx;
    logic [7:0]         head;
    logic               head_empty;
    logic               xfer;
    logic               last_byte;
    logic               rel;

    rr_pick #(
        .N  (NUM_REQ),
        .LW (LW)
    ) u_pick (
        .req   (~req_empty),
        .last  (last_q),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    // Select the granted source's head byte, empty flag and index.
    always_comb begin
        head       = '0;
        head_empty = 1'b1;
        g_idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                head       = req_data[8*i +: 8];
                head_empty = req_empty[i];
                g_idx      = LW'(i);
            end
        end
    end

    assign xfer      = ~head_empty & ~tx_full;
    assign last_byte = (head == TERM_CHAR) || (burst_q == BURST_LAST);

`ifdef TX_CRLF_EXPAND_EN
    logic expand_lf;
    // Only an LF terminator is expanded; other terminators pass through.
    assign expand_lf = (TERM_CHAR == CHAR_LF) && (head == CHAR_LF);
`endif

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= LW'(NUM_REQ - 1);
            burst_q <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            to_q    <= to_d;
        end
    end

    // Next-state: arbitration in IDLE, line tracking and release in XFER/CR.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        to_d    = to_q;
        rel     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_gnt;
                    burst_d = '0;
                    to_d    = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (xfer) begin
                    to_d = '0;
`ifdef TX_CRLF_EXPAND_EN
                    if (expand_lf) begin
                        state_d = StCr;
                    end else begin
                        burst_d = burst_q + 1'b1;
                        rel     = last_byte;
                    end
`else
                    burst_d = burst_q + 1'b1;
                    rel     = last_byte;
`endif
                end else if (head_empty) begin
                    // Backpressure with data pending is not idleness.
                    to_d = to_q + 1'b1;
                    rel  = (to_q == TO_LAST);
                end
            end
`ifdef TX_CRLF_EXPAND_EN
            StCr: begin
                // Timeout and burst counters are frozen while the LF is pending.
                rel = ~tx_full;
            end
`endif
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        if (rel) begin
            state_d = StIdle;
            grant_d = '0;
            last_d  = g_idx;
        end
    end

    // Outputs: write strobe, pop strobe and byte are decoded from the state.
    always_comb begin
        req_rd  = '0;
        wr_uart = 1'b0;
        w_data  = '0;
        busy    = (state_q != StIdle);

        unique case (state_q)
            StXfer: begin
                wr_uart = xfer;
                w_data  = head;
`ifdef TX_CRLF_EXPAND_EN
                if (expand_lf) begin
                    // CR goes out first; the LF stays at the source head.
                    w_data = CHAR_CR;
                end else begin
                    req_rd = xfer ? grant_q : '0;
                end
`else
                req_rd  = xfer ? grant_q : '0;
`endif
            end
`ifdef TX_CRLF_EXPAND_EN
            StCr: begin
                wr_uart = ~tx_full;
                w_data  = CHAR_LF;
                req_rd  = tx_full ? '0 : grant_q;
            end
`endif
            default: ;
        endcase
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (NUM_REQ=2, MAX_BURST=16, IDLE_TO=4).
// Source FIFOs are modelled as queues; a negedge monitor checks every write
// against a scoreboard filled by the stimulus. Honours TX_CRLF_EXPAND_EN.
`timescale 1ns/1ps
module tb_uart_tx_arb;

`ifdef TX_CRLF_EXPAND_EN
    localparam int LF_N = 2;
`else
    localparam int LF_N = 1;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  req_empty;
    logic [15:0] req_data;
    logic [1:0]  req_rd;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic [1:0]  grant;
    logic        busy;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] gnt;
        logic       pop;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         rd_idx;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         checks;
    int         errors;
    logic [1:0] rd_seen;
    logic       wr_seen;
    int         n0;

    uart_tx_arb #(
        .NUM_REQ   (2),
        .MAX_BURST (16),
        .TERM_CHAR (8'h0A),
        .IDLE_TO   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_empty (req_empty),
        .req_data  (req_data),
        .req_rd    (req_rd),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pending();
        return exp_q.size() - rd_idx;
    endfunction

    function automatic void refresh();
        req_empty[0]   = (q0.size() == 0);
        req_empty[1]   = (q1.size() == 0);
        req_data[7:0]  = (q0.size() != 0) ? q0[0] : 8'h00;
        req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
    endfunction

    function automatic void load(int s, logic [7:0] b);
        if (s == 0) q0.push_back(b);
        else        q1.push_back(b);
        refresh();
    endfunction

    // Expected write(s) for one source byte; LF may expand to CR,LF.
    function automatic void expb(int s, logic [7:0] b);
        logic [1:0] g;
        g = (s == 0) ? 2'b01 : 2'b10;
`ifdef TX_CRLF_EXPAND_EN
        if (b == 8'h0A) begin
            exp_q.push_back('{data: 8'h0D, gnt: g, pop: 1'b0});
            exp_q.push_back('{data: 8'h0A, gnt: g, pop: 1'b1});
        end else begin
            exp_q.push_back('{data: b, gnt: g, pop: 1'b1});
        end
`else
        exp_q.push_back('{data: b, gnt: g, pop: 1'b1});
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One clock: capture strobes at negedge, apply source pops after the edge.
    task automatic step();
        @(negedge clk);
        rd_seen = req_rd;
        wr_seen = wr_uart;
        @(posedge clk);
        #1;
        if (rd_seen[0] && q0.size() != 0) void'(q0.pop_front());
        if (rd_seen[1] && q1.size() != 0) void'(q1.pop_front());
        refresh();
    endtask

    task automatic wait_pending(int n, string name);
        int k;
        k = 0;
        while (pending() > n && k < 300) begin
            step();
            k++;
        end
        chk(name, 32'(pending() > n), 32'd0);
    endtask

    task automatic wait_idle(string name);
        int k;
        k = 0;
        while (busy && k < 50) begin
            step();
            k++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    // Monitor: every write is compared with the next scoreboard entry.
    always @(negedge clk) begin
        if (wr_uart) begin
            checks++;
            if (rd_idx >= exp_q.size()) begin
                errors++;
                $display("FAIL unexpected_write: got data=%h grant=%b, required no write",
                         w_data, grant);
            end else begin
                e = exp_q[rd_idx];
                rd_idx++;
                if (w_data !== e.data || grant !== e.gnt ||
                    req_rd !== (e.pop ? e.gnt : 2'b00) || tx_full !== 1'b0) begin
                    errors++;
                    $display("FAIL write_%0d: got data=%h grant=%b rd=%b full=%b, required data=%h grant=%b rd=%b full=0",
                             rd_idx - 1, w_data, grant, req_rd, tx_full, e.data, e.gnt,
                             e.pop ? e.gnt : 2'b00);
                end
            end
        end else if (req_rd != 2'b00) begin
            checks++;
            errors++;
            $display("FAIL pop_without_write: got rd=%b, required 00", req_rd);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rd_idx  = 0;
        reset   = 1'b0;
        tx_full = 1'b0;
        rd_seen = '0;
        wr_seen = 1'b0;
        refresh();

        // T1: single line "AB\n" from source 0.
        load(0, 8'h41); load(0, 8'h42); load(0, 8'h0A);
        expb(0, 8'h41); expb(0, 8'h42); expb(0, 8'h0A);
        step(); step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr", 32'(wr_uart), 32'd0);
        chk("rst_rd", 32'(req_rd), 32'd0);
        chk("rst_wdata", 32'(w_data), 32'd0);
        reset = 1'b1;
        step();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int k = 0; k < LF_N + 2; k++) begin
            step();
            chk("t1_consec", 32'(wr_seen), 32'd1);
        end
        chk("t1_release", 32'(grant), 32'd0);
        wait_pending(0, "t1_drain");

        // T2: fairness, source 0 refill waits for source 1's line.
        reset = 1'b0;
        step();
        load(0, 8'h58); load(0, 8'h0A); load(0, 8'h5A); load(0, 8'h0A);
        load(1, 8'h59); load(1, 8'h0A);
        expb(0, 8'h58); expb(0, 8'h0A);
        expb(1, 8'h59); expb(1, 8'h0A);
        expb(0, 8'h5A); expb(0, 8'h0A);
        reset = 1'b1;
        wait_pending(0, "t2_drain");
        wait_idle("t2_idle");

        // T3: burst limit of 16 on a 20-byte unterminated stream.
        reset = 1'b0;
        step();
        for (int i = 0; i < 20; i++) load(0, 8'(32'h61 + i));
        load(1, 8'h51); load(1, 8'h0A);
        for (int i = 0; i < 16; i++) expb(0, 8'(32'h61 + i));
        expb(1, 8'h51); expb(1, 8'h0A);
        for (int i = 16; i < 20; i++) expb(0, 8'(32'h61 + i));
        reset = 1'b1;
        wait_pending(0, "t3_drain");
        wait_idle("t3_idle");
        chk("t3_src0_empty", 32'(q0.size()), 32'd0);

        // T4: tx_full for 10 cycles mid-line.
        load(1, 8'h4D); load(1, 8'h4E); load(1, 8'h4F); load(1, 8'h50); load(1, 8'h0A);
        expb(1, 8'h4D); expb(1, 8'h4E); expb(1, 8'h4F); expb(1, 8'h50); expb(1, 8'h0A);
        n0 = pending();
        wait_pending(n0 - 2, "t4_start");
        tx_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t4_stall_wr", 32'(wr_seen), 32'd0);
            chk("t4_stall_rd", 32'(rd_seen), 32'd0);
            chk("t4_stall_grant", 32'(grant), 32'h2);
        end
        tx_full = 1'b0;
        wait_pending(0, "t4_drain");
        wait_idle("t4_idle");

        // T5: owner runs dry without a terminator; released after 4 empty cycles.
        load(0, 8'h61); load(0, 8'h62);
        load(1, 8'h52); load(1, 8'h0A);
        expb(0, 8'h61); expb(0, 8'h62);
        expb(1, 8'h52); expb(1, 8'h0A);
        n0 = pending();
        wait_pending(n0 - 2, "t5_start");
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_hold", 32'(grant), 32'h1);
        end
        step();
        chk("t5_release", 32'(grant), 32'd0);
        step();
        chk("t5_next", 32'(grant), 32'h2);
        wait_pending(0, "t5_drain");
        wait_idle("t5_idle");

`ifdef TX_CRLF_EXPAND_EN
        // T6: "A\n" goes out as 41,0D,0A with two pops.
        load(0, 8'h41); load(0, 8'h0A);
        expb(0, 8'h41); expb(0, 8'h0A);
        wait_pending(0, "t6_drain");
        wait_idle("t6_idle");
        chk("t6_src0_empty", 32'(q0.size()), 32'd0);
`endif

        // T7: reset mid-line drops the in-flight strobe; bytes stay queued.
        load(0, 8'h53); load(0, 8'h54); load(0, 8'h55); load(0, 8'h0A);
        expb(0, 8'h53);
        wait_pending(0, "t7_first");
        reset = 1'b0;
        #1;
        chk("t7_wr", 32'(wr_uart), 32'd0);
        chk("t7_rd", 32'(req_rd), 32'd0);
        chk("t7_wdata", 32'(w_data), 32'd0);
        chk("t7_grant", 32'(grant), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        step(); step();
        chk("t7_kept", 32'(q0.size()), 32'd3);
        q0.delete();
        refresh();
        step();
        reset = 1'b1;
        step(); step();
        chk("t7_after_grant", 32'(grant), 32'd0);
        chk("end_pending", 32'(pending()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one UART transmitter write port among NUM_REQ byte sources, e.g. the keyboard ASCII stream and a status/message generator.
- Each source presents a first-word-fall-through FIFO read interface: empty flag, head byte, read strobe.
- Grants are round-robin and line-locked. A grant is held until a terminator byte, a burst limit or an idle timeout, so lines from different sources never interleave on tx.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_BURST, 16, max bytes sent per grant before forced release (2..255)
TERM_CHAR, 8'h0A, terminator byte that ends a grant
IDLE_TO, 255, cycles granted source may stay empty before release (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_empty  in  NUM_REQ  per-source FIFO empty flag
req_data  in  8*NUM_REQ  per-source head byte; source i at bits [8i+7:8i]
req_rd  out  NUM_REQ  per-source pop strobe, one-hot or zero
tx_full  in  1  UART tx FIFO full
wr_uart  out  1  UART write strobe
w_data  out  8  byte to UART
grant  out  NUM_REQ  one-hot current owner, zero when idle
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE, grant=0, last pointer=NUM_REQ-1, burst count=0, timeout count=0. Outputs req_rd=0, wr_uart=0, w_data=0, busy=0.
- States: IDLE, XFER; plus CR when the optional feature is compiled in.
- IDLE:
  - If any req_empty bit is low, pick the first non-empty source searching from last+1, wrapping modulo NUM_REQ.
  - Register grant, clear counters, go to XFER next cycle. Arbitration latency is 1 cycle.
- XFER, with g = granted index:
  - xfer = ~req_empty[g] & ~tx_full.
  - wr_uart = req_rd[g] = xfer, combinational. w_data = req_data[g] byte, combinational mux, valid only while in XFER; otherwise 0.
  - Each xfer increments burst count and clears timeout count.
  - Release to IDLE after the xfer cycle if byte==TERM_CHAR or burst count reaches MAX_BURST-1 (MAX_BURST bytes sent).
  - When req_empty[g]=1, increment timeout count. At IDLE_TO, release to IDLE with no transfer that cycle.
  - tx_full=1 with data pending neither pops nor advances the timeout: backpressure is not idleness.
  - On release: last=g, grant=0.
- Fairness: after releasing source g, g has lowest priority at the next arbitration. A lone active source is re-granted after one idle cycle.
- Exactly one pop per accepted byte, never a pop without wr_uart, never wr_uart while tx_full=1.
- Simultaneous requests: round-robin order only; no fixed priority.
- Reset mid-transfer forces IDLE immediately. An in-flight combinational strobe is dropped and the byte stays in the source FIFO.
- Widths: burst count 8 bits, timeout count 8 bits, last pointer clog2(NUM_REQ) bits.

Optional Feature:
- Macro: TX_CRLF_EXPAND_EN.
- Defined:
  - When an xfer would send TERM_CHAR==8'h0A, send 8'h0D first instead and do not pop; then enter CR.
  - CR: when ~tx_full, write 8'h0A, pop source, release to IDLE. tx_full in CR simply stalls.
  - CR bytes do not count toward MAX_BURST; the timeout is frozen in CR.
- Undefined: no CR state; bytes pass through unchanged.

Decomposition:
- Shared package uart_arb_pkg: state encoding (IDLE, XFER, CR), CHAR_CR=8'h0D, CHAR_LF=8'h0A, counter width constant.
- One sub-module: rr_pick, a combinational round-robin picker. Inputs: request vector, last pointer. Outputs: one-hot next grant, found flag. Reused by other arbiters.

Test Plan:
- Source 0 holds "AB\n" (41,42,0A), source 1 empty, tx_full=0.
  - Expect grant=01 one cycle after reset release, then 3 consecutive wr_uart with w_data 41,42,0A, then grant=0.
- Both sources hold "X\n" and "Y\n" from reset.
  - Expect order 58,0A then 59,0A.
  - Refill source 0 with "Z\n": it is granted next only after source 1's line.
- Source 0 holds 20 bytes with no 0A, MAX_BURST=16.
  - Expect release after exactly 16 writes; source 1 "Q\n" is then sent; source 0 resumes with byte 17.
- tx_full held high 10 cycles mid-line.
  - Expect wr_uart=0 and req_rd=0 throughout, no timeout release, resume at the same byte.
- Granted source goes empty with no terminator, IDLE_TO=4.
  - Expect release to IDLE after 4 empty cycles; a pending source 1 is granted next.
- With TX_CRLF_EXPAND_EN, source 0 holds "A\n".
  - Expect writes 41,0D,0A and exactly 2 pops.
  - Assert reset low mid-line: outputs zero immediately, unsent bytes remain in the FIFO.
